// File: rtl/muxn_seq.sv
// Registered N-to-1 W-bit mux with valid/ready output, manual select or channel scan.
// Optional MUXN_SEQ_PARITY_EN adds z_par, the XOR reduction of the captured z.

module muxn_seq_lane #(
  parameter int W    = 8,
  parameter int SELW = 2,
  parameter int IDX  = 0
) (
  input  logic [SELW-1:0] ch,
  input  logic [W-1:0]    d,
  output logic [W-1:0]    q
);
  assign q = (ch == SELW'(IDX)) ? d : '0;
endmodule

module muxn_seq #(
  parameter  int N         = 4,
  parameter  int W         = 8,
  parameter  int SCAN_HOLD = 1,
  localparam int SELW      = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  d,
  input  logic [SELW-1:0] sel,
  input  logic            mode,
  input  logic            in_valid,
  output logic [W-1:0]    z,
  output logic [SELW-1:0] z_ch,
  output logic            z_valid,
  input  logic            z_ready,
  output logic            err
`ifdef MUXN_SEQ_PARITY_EN
  ,output logic           z_par
`endif
);
  localparam int             HCW   = (SCAN_HOLD > 1) ? $clog2(SCAN_HOLD) : 1;
  localparam logic [SELW:0]  N_EXT = (SELW+1)'(N);

  logic [SELW-1:0]       ptr;
  logic [HCW-1:0]        hcnt;
  logic [SELW-1:0]       ch;
  logic                  accept;
  logic                  ch_bad;
  logic [N-1:0][W-1:0]   lane_q;
  logic [W-1:0]          zsel;

  assign accept = in_valid && (!z_valid || z_ready);
  assign ch     = mode ? ptr : sel;
  assign ch_bad = {1'b0, ch} >= N_EXT;

  // Each lane gates its channel onto the OR tree; an out-of-range ch matches no lane and yields 0.
  for (genvar i = 0; i < N; i++) begin : g_lane
    muxn_seq_lane #(.W(W), .SELW(SELW), .IDX(i)) u_lane (
      .ch (ch),
      .d  (d[i*W +: W]),
      .q  (lane_q[i])
    );
  end

  always_comb begin
    zsel = '0;
    for (int i = 0; i < N; i++) zsel |= lane_q[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      z       <= '0;
      z_ch    <= '0;
      z_valid <= 1'b0;
      err     <= 1'b0;
    end else if (accept) begin
      z       <= zsel;
      z_ch    <= ch;
      z_valid <= 1'b1;
      if (ch_bad) err <= 1'b1;
    end else if (z_valid && z_ready) begin
      z_valid <= 1'b0;
    end
  end

`ifdef MUXN_SEQ_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst)         z_par <= 1'b0;
    else if (accept) z_par <= ^zsel;
  end
`endif

  // Scan state is parked at channel 0 whenever manual mode is selected.
  always_ff @(posedge clk) begin
    if (rst || !mode) begin
      ptr  <= '0;
      hcnt <= '0;
    end else if (accept) begin
      if (hcnt == HCW'(SCAN_HOLD-1)) begin
        hcnt <= '0;
        ptr  <= (ptr == SELW'(N-1)) ? '0 : ptr + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_muxn_seq.sv
// Bench for muxn_seq: two instances (N=4/SCAN_HOLD=2 and N=3/SCAN_HOLD=1), directed plan then random traffic.
module tb_muxn_seq;
  logic        clk = 1'b0;
  logic        rst, mode, iv, zr;
  logic [1:0]  sel0, sel1;
  logic [7:0]  dch [2][4];
  logic [31:0] d0;
  logic [23:0] d1;
  logic [7:0]  z0, z1;
  logic [1:0]  zc0, zc1;
  logic        zv0, zv1, err0, err1;
`ifdef MUXN_SEQ_PARITY_EN
  logic        zp0, zp1;
`endif

  int checks = 0;
  int errors = 0;

  // reference state: captured sample plus count of scan-mode accepts since scan start
  int          nn [2] = '{4, 3};
  int          sh [2] = '{2, 1};
  logic [7:0]  mz [2];
  logic [1:0]  mch [2];
  logic        mv [2], merr [2];
  int          k [2];

  always #5 clk = ~clk;

  always_comb begin
    d0 = '0;
    d1 = '0;
    for (int i = 0; i < 4; i++) d0[i*8 +: 8] = dch[0][i];
    for (int i = 0; i < 3; i++) d1[i*8 +: 8] = dch[1][i];
  end

  muxn_seq #(.N(4), .W(8), .SCAN_HOLD(2)) u_dut0 (
    .clk(clk), .rst(rst), .d(d0), .sel(sel0), .mode(mode), .in_valid(iv),
    .z(z0), .z_ch(zc0), .z_valid(zv0), .z_ready(zr), .err(err0)
`ifdef MUXN_SEQ_PARITY_EN
    , .z_par(zp0)
`endif
  );

  muxn_seq #(.N(3), .W(8), .SCAN_HOLD(1)) u_dut1 (
    .clk(clk), .rst(rst), .d(d1), .sel(sel1), .mode(mode), .in_valid(iv),
    .z(z1), .z_ch(zc1), .z_valid(zv1), .z_ready(zr), .err(err1)
`ifdef MUXN_SEQ_PARITY_EN
    , .z_par(zp1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int u = 0; u < 2; u++) begin
      bit acc;
      int c;
      acc = iv && (!mv[u] || zr);
      if (rst) begin
        mz[u] = 0; mch[u] = 0; mv[u] = 0; merr[u] = 0; k[u] = 0;
      end else begin
        if (acc) begin
          c = mode ? (k[u] / sh[u]) % nn[u] : int'(u == 0 ? sel0 : sel1);
          if (c >= nn[u]) begin
            mz[u] = 0; merr[u] = 1;
          end else begin
            mz[u] = dch[u][c];
          end
          mch[u] = 2'(c);
          mv[u]  = 1;
          if (mode) k[u]++;
        end else if (mv[u] && zr) begin
          mv[u] = 0;
        end
        if (!mode) k[u] = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("z0", z0, mz[0]);     chk("zch0", zc0, mch[0]);
    chk("zv0", zv0, mv[0]);   chk("err0", err0, merr[0]);
    chk("z1", z1, mz[1]);     chk("zch1", zc1, mch[1]);
    chk("zv1", zv1, mv[1]);   chk("err1", err1, merr[1]);
`ifdef MUXN_SEQ_PARITY_EN
    chk("par0", zp0, ^mz[0]); chk("par1", zp1, ^mz[1]);
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    int seq [10];
    seq = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    rst = 1; mode = 0; iv = 0; zr = 1; sel0 = 0; sel1 = 0;
    for (int u = 0; u < 2; u++) begin
      mz[u] = 0; mch[u] = 0; mv[u] = 0; merr[u] = 0; k[u] = 0;
      for (int i = 0; i < 4; i++) dch[u][i] = 8'h00;
    end

    // reset held two cycles
    cyc(); cyc();
    chk("rst_z", z0, 0); chk("rst_zch", zc0, 0); chk("rst_zv", zv0, 0); chk("rst_err", err0, 0);
    rst = 0;

    // manual stepping
    dch[0] = '{8'h11, 8'h22, 8'h33, 8'h44};
    dch[1] = '{8'h11, 8'h22, 8'h33, 8'h00};
    iv = 1; zr = 1;
    for (int i = 0; i < 4; i++) begin
      sel0 = 2'(i); sel1 = 2'(i % 3);
      cyc();
      chk("man_z", z0, 8'h11 * (i + 1)); chk("man_zch", zc0, i); chk("man_zv", zv0, 1);
    end

    // backpressure
    sel0 = 2; cyc();
    chk("bp_cap", z0, 8'h33);
    zr = 0; sel0 = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_hold", z0, 8'h33); chk("bp_zv", zv0, 1);
    end
    zr = 1; cyc();
    chk("bp_release", z0, 8'h22);

    // scan mode
    mode = 1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("scan_seq", zc0, seq[i]);
    end
    mode = 0; sel0 = 3; cyc();
    mode = 1; cyc();
    chk("scan_restart", zc0, 0);

    // illegal select on N=3
    mode = 0; sel1 = 3; cyc();
    chk("bad_z", z1, 0); chk("bad_zch", zc1, 3); chk("bad_err", err1, 1);
    sel1 = 1; cyc(); cyc();
    chk("err_sticky", err1, 1); chk("legal_z", z1, 8'h22);
    rst = 1; cyc(); rst = 0;
    chk("err_clr", err1, 0);

    // drain and parity
    dch[0][0] = 8'h07; sel0 = 0; iv = 1; zr = 1; cyc();
`ifdef MUXN_SEQ_PARITY_EN
    chk("par07", zp0, 1);
`endif
    iv = 0; cyc();
    chk("drain_zv", zv0, 0); chk("drain_z", z0, 8'h07);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst  = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      iv   = ($urandom_range(0, 3) != 0);
      zr   = ($urandom_range(0, 2) != 0);
      sel0 = 2'($urandom_range(0, 3));
      sel1 = 2'($urandom_range(0, 3));
      for (int u = 0; u < 2; u++)
        for (int i = 0; i < 4; i++) dch[u][i] = 8'($urandom);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/muxn_seq.md
Name: muxn_seq

Overview:
Parametrised N-to-1, W-bit registered multiplexer with valid/ready output handshake. Supports manual channel selection or an automatic scan mode that walks all channels in order. Successor to the 2:1 combinational mux; used wherever several sampled buses share one downstream consumer.

Parameters:
N, 4, number of input channels (N >= 2)
W, 8, data width per channel
SCAN_HOLD, 1, accepted captures per channel before scan mode advances (>= 1)
SELW (localparam), $clog2(N), width of channel index

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
d  in  N*W  packed channel data; channel i at d[i*W +: W]
sel  in  SELW  manual channel select (mode=0)
mode  in  1  0 = manual select, 1 = scan
in_valid  in  1  request to capture one sample
z  out  W  registered selected data
z_ch  out  SELW  channel index that produced z
z_valid  out  1  z/z_ch hold a sample not yet consumed
z_ready  in  1  downstream accepts z this cycle
err  out  1  sticky: manual sel >= N was captured

Behaviour:
- Single clock domain; rst synchronous, active-high, sampled on rising clk edge; overrides everything else that cycle.
- Reset values: z=0, z_ch=0, z_valid=0, err=0; scan pointer=0; hold count=0.
- accept = in_valid && (!z_valid || z_ready). No combinational path from z_ready to any output.
- Channel choice ch: mode=0 -> sel; mode=1 -> scan pointer.
- On accept: z <= d[ch*W +: W], z_ch <= ch, z_valid <= 1. Latency: 1 cycle from accept to z_valid.
- sel >= N (possible only when N is not a power of 2) in manual mode: z <= 0, z_ch <= sel, z_valid <= 1, err <= 1. err clears only on rst.
- No accept and z_valid && z_ready: z_valid <= 0; z and z_ch hold their last values.
- Accept and z_ready on the same cycle: new sample replaces old one; z_valid stays 1 (full throughput, one sample per cycle).
- z_valid && !z_ready: z and z_ch are stable; in_valid is ignored (not queued). The upstream holds or drops the request as it chooses.
- Scan counters: while mode=0, scan pointer and hold count are forced to 0, so scan always starts at channel 0.
- In mode=1, on each accept the hold count increments. When hold count reaches SCAN_HOLD-1 it resets to 0 and the scan pointer advances. The pointer wraps from N-1 to 0.
- mode changes take effect on the next accept. A mode change while z_valid=1 does not alter the held z.
- d and sel are sampled only at accept; changes at other times have no effect.
- rst during a stalled transfer: the sample is discarded (z_valid=0) and scan restarts at channel 0.

Optional Feature:
MUXN_SEQ_PARITY_EN
- Defined: adds output port z_par (1 bit) = even parity (XOR reduction) of the captured data. It is registered alongside z, resets to 0, and follows the same hold and stall rules as z.
- Undefined: z_par port and its logic are absent; all other behaviour is identical.

Test Plan:
- N=4, W=8. Reset, then hold rst=1 for 2 cycles -> z=0, z_ch=0, z_valid=0, err=0.
- Manual mode: d={8'h44,8'h33,8'h22,8'h11}, z_ready=1. Step sel 0..3 with in_valid=1 each cycle -> one cycle later z=11,22,33,44 and z_ch=0..3. z_valid stays high every cycle.
- Backpressure: capture sel=2, then z_ready=0 for 3 cycles while sel=1 and in_valid=1 -> z stays 8'h33 and z_valid stays 1. Raise z_ready with in_valid=1 -> next cycle z=8'h22.
- Scan mode: SCAN_HOLD=2, mode=1, in_valid=1, z_ready=1 for 10 cycles -> z_ch sequence 0,0,1,1,2,2,3,3,0,0. Then mode=0 and back to 1 -> scan restarts at ch 0.
- N=3: manual sel=3 with in_valid -> z=0, z_ch=3, err=1. err stays 1 after further legal captures and clears only on rst.
- Drain: in_valid=0, z_ready=1 after a capture -> z_valid drops next cycle with z unchanged. With MUXN_SEQ_PARITY_EN, capturing 8'h07 gives z_par=1.
